uart_mmio_ctrl: RTL and testbench

//  Memory-mapped controller that lets the SAP-2 CPU use the UART. Buffers bytes from

---
 rtl/uart_mmio_ctrl.sv | 128 ++++++++++++
 tb/tb_uart_mmio_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: RX FIFO fed by uart_receiver, TX holding register
// sequenced into uart_transmitter, sticky error flags and a level interrupt.
module uart_mmio_ctrl #(
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] cpu_addr,
    input  logic       cpu_wr_en,
    input  logic       cpu_rd_en,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       rx_frame_err,
    output logic [7:0] tx_byte,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       irq
);
    localparam int PTR_W = $clog2(RX_FIFO_DEPTH);
    localparam int CNT_W = $clog2(RX_FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RX_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} tx_state_e;

    logic [7:0]       mem_q [RX_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       rdata_q, rdata_d;
    logic [1:0]       ctrl_q;
    logic             frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic [7:0]       hold_q, tx_byte_q;
    logic             hold_full_q, tx_start_q;
    tx_state_e        state_q;

    logic       rd_req, sts_wr, rx_avail, fifo_full, push_req, push, pop;
    logic [7:0] status;

    // A simultaneous write wins over the read, so the read side is gated here.
    assign rd_req    = cpu_rd_en & ~cpu_wr_en;
    assign sts_wr    = cpu_wr_en & (cpu_addr == 2'd1);
    assign rx_avail  = (count_q != '0);
    assign fifo_full = (count_q == FULL_CNT);
    assign push_req  = rx_valid & ~rx_frame_err;
    assign pop       = rd_req & (cpu_addr == 2'd0) & rx_avail;
    assign push      = push_req & (~fifo_full | pop);
    assign status    = {4'b0, frame_err_q, overrun_q, ~hold_full_q, rx_avail};

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);

        frame_err_d = (frame_err_q & ~(sts_wr & cpu_wdata[3])) | (rx_valid & rx_frame_err);
        overrun_d   = (overrun_q & ~(sts_wr & cpu_wdata[2])) | (push_req & fifo_full & ~pop);

        rdata_d = rdata_q;
        if (rd_req) begin
            case (cpu_addr)
                2'd0:    rdata_d = rx_avail ? mem_q[rd_ptr_q] : 8'h00;
                2'd1:    rdata_d = status;
                2'd2:    rdata_d = {6'b0, ctrl_q};
                default: rdata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_byte;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rdata_q     <= 8'h00;
            ctrl_q      <= 2'b00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q     <= count_d;
            rdata_q     <= rdata_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            if (cpu_wr_en && cpu_addr == 2'd2) ctrl_q <= cpu_wdata[1:0];
        end
    end

    // Holding register stays full from the DATA write until the transmitter drops busy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            tx_byte_q   <= 8'h00;
            tx_start_q  <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            if (cpu_wr_en && cpu_addr == 2'd0 && !hold_full_q) begin
                hold_q      <= cpu_wdata;
                hold_full_q <= 1'b1;
            end
            case (state_q)
                IDLE: if (hold_full_q && !tx_busy) begin
                    state_q    <= START;
                    tx_start_q <= 1'b1;
                    tx_byte_q  <= hold_q;
                end
                START:   state_q <= WAIT_HI;
                WAIT_HI: if (tx_busy) state_q <= WAIT_LO;
                WAIT_LO: if (!tx_busy) begin
                    state_q     <= IDLE;
                    hold_full_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_rdata = rdata_q;
    assign tx_byte   = tx_byte_q;
    assign tx_start  = tx_start_q;
    assign irq       = (ctrl_q[0] & rx_avail) | (ctrl_q[1] & ~hold_full_q);
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_uart_mmio_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] cpu_addr = 2'd0;
    logic       cpu_wr_en = 1'b0, cpu_rd_en = 1'b0;
    logic [7:0] cpu_wdata = 8'h00;
    logic [7:0] cpu_rdata;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0, rx_frame_err = 1'b0;
    logic [7:0] tx_byte;
    logic       tx_start;
    logic       tx_busy = 1'b0;
    logic       irq;

    int n_chk = 0;
    int n_pass = 0;

    uart_mmio_ctrl #(.RX_FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wr_en(cpu_wr_en),
        .cpu_rd_en(cpu_rd_en), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err),
        .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        cpu_addr = a; cpu_rd_en = 1'b1;
        cyc();
        cpu_rd_en = 1'b0;
        d = cpu_rdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_wdata = d; cpu_wr_en = 1'b1;
        cyc();
        cpu_wr_en = 1'b0;
    endtask

    task automatic rx(input logic [7:0] b, input logic fe);
        rx_byte = b; rx_frame_err = fe; rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0; rx_frame_err = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        int starts;
        logic [7:0] exp_fifo [4];

        // Reset held for 10 cycles
        @(negedge clk);
        repeat (10) cyc();
        chk("rst_rdata", cpu_rdata, 8'h00);
        chk("rst_txbyte", tx_byte, 8'h00);
        chk("rst_txstart", {7'b0, tx_start}, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        reset = 1'b1;
        cyc();
        rd(2'd1, d); chk("rst_status", d, 8'h02);

        // RX FIFO ordering and empty read
        rx(8'h41, 1'b0); rx(8'h42, 1'b0); rx(8'h43, 1'b0);
        rd(2'd1, d); chk("fifo_status", d, 8'h03);
        rd(2'd0, d); chk("fifo_rd0", d, 8'h41);
        rd(2'd0, d); chk("fifo_rd1", d, 8'h42);
        rd(2'd0, d); chk("fifo_rd2", d, 8'h43);
        rd(2'd0, d); chk("fifo_empty_rd", d, 8'h00);
        rd(2'd1, d); chk("fifo_status_empty", d, 8'h02);

        // Overrun: fifth byte dropped
        for (int i = 0; i < 5; i++) rx(8'h10 + 8'(i), 1'b0);
        rd(2'd1, d); chk("ovr_status", d, 8'h07);
        for (int i = 0; i < 4; i++) begin
            rd(2'd0, d); chk($sformatf("ovr_rd%0d", i), d, 8'h10 + 8'(i));
        end
        rd(2'd1, d); chk("ovr_sticky", d, 8'h06);
        wr(2'd1, 8'h04);
        rd(2'd1, d); chk("ovr_cleared", d, 8'h02);

        // Frame error sets sticky flag, no push
        rx(8'h55, 1'b1);
        rd(2'd1, d); chk("ferr_status", d, 8'h0A);
        rd(2'd0, d); chk("ferr_no_push", d, 8'h00);
        wr(2'd1, 8'h08);
        rd(2'd1, d); chk("ferr_cleared", d, 8'h02);

        // Simultaneous read+write: write wins, CTRL read-back, reserved address
        cpu_addr = 2'd2; cpu_wdata = 8'hFE; cpu_wr_en = 1'b1; cpu_rd_en = 1'b1;
        cyc();
        cpu_wr_en = 1'b0; cpu_rd_en = 1'b0;
        chk("rdwr_read_ignored", cpu_rdata, 8'h02);
        rd(2'd2, d); chk("ctrl_rb", d, 8'h02);
        rd(2'd3, d); chk("addr3_rd", d, 8'h00);

        // TX handshake with tx_irq_en set (CTRL=0x02 from above)
        chk("tx_irq_idle", {7'b0, irq}, 8'h01);
        wr(2'd0, 8'hA5);
        chk("tx_irq_full", {7'b0, irq}, 8'h00);
        cyc();
        chk("tx_start_pulse", {7'b0, tx_start}, 8'h01);
        chk("tx_byte", tx_byte, 8'hA5);
        starts = 1;
        tx_busy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i == 10) begin cpu_addr = 2'd0; cpu_wdata = 8'h5A; cpu_wr_en = 1'b1; end
            if (i == 20) begin cpu_addr = 2'd1; cpu_rd_en = 1'b1; end
            cyc();
            cpu_wr_en = 1'b0; cpu_rd_en = 1'b0;
            if (i == 20) chk("tx_status_busy", cpu_rdata, 8'h00);
            if (tx_start) starts++;
        end
        chk("tx_irq_busy", {7'b0, irq}, 8'h00);
        tx_busy = 1'b0;
        cyc();
        chk("tx_ready_after_busy", {7'b0, irq}, 8'h01);
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (tx_start) starts++;
        end
        chk("tx_start_count", 8'(starts), 8'h01);
        chk("tx_byte_held", tx_byte, 8'hA5);
        rd(2'd1, d); chk("tx_status_done", d, 8'h02);

        // Full FIFO with simultaneous push and pop under rx_irq_en
        wr(2'd2, 8'h01);
        chk("irq_empty", {7'b0, irq}, 8'h00);
        for (int i = 0; i < 4; i++) rx(8'h60 + 8'(i), 1'b0);
        chk("irq_full", {7'b0, irq}, 8'h01);
        rx_byte = 8'h77; rx_valid = 1'b1; cpu_addr = 2'd0; cpu_rd_en = 1'b1;
        cyc();
        rx_valid = 1'b0; cpu_rd_en = 1'b0;
        chk("sim_pop", cpu_rdata, 8'h60);
        exp_fifo[0] = 8'h61; exp_fifo[1] = 8'h62; exp_fifo[2] = 8'h63; exp_fifo[3] = 8'h77;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_irq%0d", i), {7'b0, irq}, 8'h01);
            rd(2'd0, d); chk($sformatf("drain_rd%0d", i), d, exp_fifo[i]);
        end
        chk("irq_drained", {7'b0, irq}, 8'h00);
        rd(2'd1, d); chk("sim_no_overrun", d, 8'h02);

        // Reset mid-transmission abandons the frame
        wr(2'd0, 8'h33);
        cyc();
        chk("mid_start", {7'b0, tx_start}, 8'h01);
        tx_busy = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        chk("mid_rst_txbyte", tx_byte, 8'h00);
        chk("mid_rst_irq", {7'b0, irq}, 8'h00);
        reset = 1'b1;
        tx_busy = 1'b0;
        rd(2'd1, d); chk("mid_rst_status", d, 8'h02);
        rd(2'd2, d); chk("mid_rst_ctrl", d, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
